seq_div4: RTL and testbench

Sequential restoring divider. It is the inverse of the 4-bit partial-product multiplier datapath: it takes a dividend and a divisor and returns quotient and remainder by shift-and-subtract, one quotient bit per clock. It sits beside the multiplier in the arithmetic library and reuses the same operand width convention. Control is a start/busy/done handshake, so a host FSM can issue back-to-back operations.

---
 rtl/seq_div4_if.sv | 26 ++
 rtl/seq_div4.sv | 140 ++++++++++++++
 tb/tb_seq_div4.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div4_if.sv
// Handshake/operand bundle for the sequential divider.
//   start/a/b : request and operands (driven by the host)
//   busy/done : progress and one-cycle completion pulse (driven by the divider)
//   q/r/dz    : quotient, remainder and divide-by-zero flag of the last result
interface seq_div4_if #(
  parameter int unsigned W = 4
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;

  modport master (
    output start, a, b,
    input  busy, done, q, r, dz
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, dz
  );
endinterface

// File: rtl/seq_div4.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : seq_div4_if.slave (start/a/b in; busy/done/q/r/dz out, all registered)
module seq_div4 #(
  parameter int unsigned W = 4
) (
  input  logic       clk,
  input  logic       rst,
  seq_div4_if.slave  bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  dvd_q, dvd_d;   // dividend, shifted left each step
  logic [W-1:0]  dvs_q, dvs_d;   // divisor
  logic [W-1:0]  rem_q, rem_d;   // partial remainder after restore
  logic [W-1:0]  quo_q, quo_d;   // quotient bits collected so far
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic          dz_q, dz_d;

  logic [W:0]    shifted_c;
  logic [W:0]    diff_c;
  logic          neg_c;
  logic [W-1:0]  rem_step_c;
  logic [W-1:0]  quo_step_c;

  // One restoring step. The restored remainder is always below the divisor,
  // so it is kept in W bits; the W+1-bit partial exists only within the step.
  // |diff| < 2^W, so bit W of the W+1-bit difference is a valid sign bit.
  always_comb begin
    shifted_c  = {rem_q, dvd_q[W-1]};
    diff_c     = shifted_c - {1'b0, dvs_q};
    neg_c      = diff_c[W];
    rem_step_c = neg_c ? shifted_c[W-1:0] : diff_c[W-1:0];
    quo_step_c = {quo_q[W-2:0], ~neg_c};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          if (bus.b != '0) begin
            dvd_d   = bus.a;
            dvs_d   = bus.b;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            // Divide by zero resolves immediately without iterating.
            q_d     = '1;
            r_d     = bus.a;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_step_c;
        quo_d = quo_step_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          q_d     = quo_step_c;
          r_d     = rem_step_c;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_seq_div4.sv
// Self-checking bench for seq_div4 (W=4) against an arithmetic reference model.
module tb_seq_div4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seq_div4_if #(.W(4)) bus ();

  seq_div4 #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation (start sampled at the next edge) and wait for done.
  // lat = edges after the start edge until done is seen (20 = timed out).
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                       output int lat, output int busy_cyc,
                       output logic [3:0] qv, output logic [3:0] rv,
                       output logic dzv, output logic busy_at_done,
                       output bit held);
    logic [3:0] pq;
    logic [3:0] pr;
    logic       pdz;
    pq = bus.q;
    pr = bus.r;
    pdz = bus.dz;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    held = 1'b1;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.q !== pq || bus.r !== pr || bus.dz !== pdz) held = 1'b0;
      tick();
      lat++;
    end
    qv = bus.q;
    rv = bus.r;
    dzv = bus.dz;
    busy_at_done = bus.busy;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.q, bus.r, bus.dz} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               bus.busy, bus.done, bus.q, bus.r, bus.dz);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int lat, bc; logic [3:0] qv, rv; logic dzv, bd; bit held;
    do_op(4'd13, 4'd3, lat, bc, qv, rv, dzv, bd, held);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    checks++;
    if (qv !== 4'd4 || rv !== 4'd1 || dzv !== 1'b0 || bd !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b busy=%b want q=4 r=1 dz=0 busy=0",
               qv, rv, dzv, bd);
    end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL basic_hold: results changed during RUN"); end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done=%b want 0", bus.done); end
  endtask

  task automatic test_boundaries();
    logic [3:0] ta [5] = '{4'd15, 4'd5, 4'd0, 4'd15, 4'd1};
    logic [3:0] tb [5] = '{4'd1,  4'd7, 4'd9, 4'd15, 4'd2};
    logic [3:0] tq [5] = '{4'd15, 4'd0, 4'd0, 4'd1,  4'd0};
    logic [3:0] tr [5] = '{4'd0,  4'd5, 4'd0, 4'd0,  4'd1};
    int lat, bc; logic [3:0] qv, rv; logic dzv, bd; bit held;
    for (int i = 0; i < 5; i++) begin
      tick();
      do_op(ta[i], tb[i], lat, bc, qv, rv, dzv, bd, held);
      checks++;
      if (lat !== 4 || qv !== tq[i] || rv !== tr[i] || dzv !== 1'b0) begin
        errors++;
        $display("FAIL boundary_%0d/%0d: got lat=%0d q=%0d r=%0d dz=%b want lat=4 q=%0d r=%0d dz=0",
                 ta[i], tb[i], lat, qv, rv, dzv, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [3:0] qv, rv; logic dzv, bd; bit held;
    tick();
    do_op(4'd9, 4'd0, lat, bc, qv, rv, dzv, bd, held);
    checks++;
    if (lat !== 0 || bd !== 1'b0) begin
      errors++;
      $display("FAIL dz_latency: got edges=%0d busy=%b want edges=0 busy=0", lat, bd);
    end
    checks++;
    if (qv !== 4'd15 || rv !== 4'd9 || dzv !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: got q=%0d r=%0d dz=%b want q=15 r=9 dz=1", qv, rv, dzv);
    end
    tick();
    do_op(4'd8, 4'd2, lat, bc, qv, rv, dzv, bd, held);
    checks++;
    if (qv !== 4'd4 || rv !== 4'd0 || dzv !== 1'b0 || held !== 1'b1) begin
      errors++;
      $display("FAIL dz_clear: got q=%0d r=%0d dz=%b held=%b want q=4 r=0 dz=0 held=1",
               qv, rv, dzv, held);
    end
  endtask

  task automatic test_ignored_start();
    int ndone, dk; logic [3:0] cq, cr;
    ndone = 0; dk = -1; cq = '0; cr = '0;
    tick();
    bus.a = 4'd12; bus.b = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin bus.a = 4'd7; bus.b = 4'd2; end
      bus.start = (k == 2);
      tick();
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin ndone++; dk = k; cq = bus.q; cr = bus.r; end
    end
    checks++;
    if (ndone !== 1 || dk !== 4) begin
      errors++;
      $display("FAIL ignored_done_count: got %0d dones, last at edge %0d; want 1 at edge 4", ndone, dk);
    end
    checks++;
    if (cq !== 4'd2 || cr !== 4'd2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_result: got q=%0d r=%0d busy=%b want q=2 r=2 busy=0", cq, cr, bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, nd; logic [3:0] qv, rv; logic dzv, bd; bit held;
    tick();
    bus.a = 4'd14; bus.b = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.q, bus.r, bus.dz} !== 11'd0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               bus.busy, bus.done, bus.q, bus.r, bus.dz);
    end
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", nd); end
    do_op(4'd14, 4'd3, lat, bc, qv, rv, dzv, bd, held);
    checks++;
    if (lat !== 4 || qv !== 4'd4 || rv !== 4'd2 || dzv !== 1'b0) begin
      errors++;
      $display("FAIL abort_retry: got lat=%0d q=%0d r=%0d dz=%b want lat=4 q=4 r=2 dz=0", lat, qv, rv, dzv);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [3:0] qv, rv; logic dzv, bd; bit held;
    tick();
    do_op(4'd13, 4'd3, lat, bc, qv, rv, dzv, bd, held);
    checks++;
    if (qv !== 4'd4 || rv !== 4'd1) begin
      errors++;
      $display("FAIL b2b_first: got q=%0d r=%0d want q=4 r=1", qv, rv);
    end
    // Still in the done cycle: the next start is accepted right here.
    do_op(4'd11, 4'd4, lat, bc, qv, rv, dzv, bd, held);
    checks++;
    if (lat !== 4 || qv !== 4'd2 || rv !== 4'd3 || dzv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d dz=%b want lat=4 q=2 r=3 dz=0", lat, qv, rv, dzv);
    end
  endtask

  task automatic test_sweep();
    int lat, bc, elat, bad; logic [3:0] qv, rv, eq, er; logic dzv, bd, edz; bit held;
    bad = 0;
    tick();
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        edz  = (bi == 0);
        eq   = edz ? 4'd15 : 4'(ai / bi);
        er   = edz ? 4'(ai) : 4'(ai % bi);
        elat = edz ? 0 : 4;
        do_op(4'(ai), 4'(bi), lat, bc, qv, rv, dzv, bd, held);
        checks++;
        if (lat !== elat || qv !== eq || rv !== er || dzv !== edz || held !== 1'b1) begin
          errors++;
          if (bad < 10)
            $display("FAIL sweep_%0d/%0d: got lat=%0d q=%0d r=%0d dz=%b held=%b want lat=%0d q=%0d r=%0d dz=%b",
                     ai, bi, lat, qv, rv, dzv, held, elat, eq, er, edz);
          bad++;
        end
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, elat, gap; logic [3:0] av, bv, qv, rv, eq, er; logic dzv, bd, edz; bit held;
    for (int n = 0; n < 60; n++) begin
      av  = 4'($urandom_range(0, 15));
      bv  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      edz  = (bv == 4'd0);
      eq   = edz ? 4'd15 : 4'(int'(av) / int'(bv));
      er   = edz ? av : 4'(int'(av) % int'(bv));
      elat = edz ? 0 : 4;
      do_op(av, bv, lat, bc, qv, rv, dzv, bd, held);
      checks++;
      if (lat !== elat || qv !== eq || rv !== er || dzv !== edz) begin
        errors++;
        $display("FAIL random_%0d/%0d: got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=%b",
                 av, bv, lat, qv, rv, dzv, elat, eq, er, edz);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
